preg_free_fifo: RTL and testbench

Physical-register free list for the R10K-style rename stage: a circular FIFO of free physical register tags that feeds a new destination tag to the ROB and map table at every dispatch. It also takes back the old tag (Told) that the ROB releases at retirement. Branch misprediction recovery restores the head pointer in a single cycle from a checkpoint, with no walk of the array. It sits between the ROB retire port and the dispatch logic, alongside the map table.

---
 rtl/sys_defs.sv | 13 +
 rtl/preg_free_fifo.sv | 95 +++++++++
 tb/tb_preg_free_fifo.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sys_defs.sv
// Shared rename-stage definitions: physical tag and free-list pointer types.
// Used by the free list, ROB, map table and branch stack.
package sys_defs;

  localparam int unsigned PRF_W    = 6;
  localparam int unsigned FL_DEPTH = 32;
  localparam int unsigned HT_W     = 5;

  typedef logic [PRF_W-1:0] preg_t;
  // The MSB is the wrap bit. It distinguishes full from empty when the indices match.
  typedef logic [HT_W:0]    fl_ptr_t;

endpackage

// File: rtl/preg_free_fifo.sv
// Physical-register free list. This is a circular FIFO of free tags with a wrap-bit
// head and tail. Dispatch pops at the head, and retire pushes Told at the tail.
// Branch recovery reloads the head from a checkpoint in one cycle.
// Optional macro FL_DEBUG_EN adds the debug ports array_o, head_o and tail_o,
// plus simulation assertions.
module preg_free_fifo
  import sys_defs::*;
#(
  parameter int unsigned PRF_W    = sys_defs::PRF_W,
  parameter int unsigned FL_DEPTH = sys_defs::FL_DEPTH,
  parameter int unsigned HT_W     = sys_defs::HT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dispatch_en_i,
  input  logic             retire_en_i,
  input  logic [PRF_W-1:0] retire_preg_i,
  input  logic             recover_en_i,
  input  logic [HT_W:0]    recover_head_i,
`ifdef FL_DEBUG_EN
  output logic [PRF_W-1:0] array_o [FL_DEPTH],
  output logic [HT_W:0]    head_o,
  output logic [HT_W:0]    tail_o,
`endif
  output logic             free_preg_vld_o,
  output logic [PRF_W-1:0] free_preg_o,
  output logic [HT_W:0]    free_preg_cur_head_o,
  output logic [HT_W:0]    free_cnt_o
);

  logic [PRF_W-1:0] fl_array [FL_DEPTH];
  logic [HT_W:0]    head;
  logic [HT_W:0]    tail;
  logic             do_pop;

  // Outputs depend on registered state only, so there is no path from an input to an output.
  always_comb begin
    free_cnt_o           = tail - head;
    free_preg_vld_o      = (head != tail);
    free_preg_o          = fl_array[head[HT_W-1:0]];
    free_preg_cur_head_o = head;
    do_pop               = dispatch_en_i && free_preg_vld_o && !recover_en_i;
  end

  // Pointer and array update. Recovery overrides a pop. The push is independent of both.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= {1'b1, {HT_W{1'b0}}};
      for (int unsigned i = 0; i < FL_DEPTH; i++) begin
        fl_array[i] <= PRF_W'(FL_DEPTH + i);
      end
    end else begin
      if (retire_en_i) begin
        fl_array[tail[HT_W-1:0]] <= retire_preg_i;
        tail                     <= tail + (HT_W+1)'(1);
      end
      if (recover_en_i) begin
        head <= recover_head_i;
      end else if (do_pop) begin
        head <= head + (HT_W+1)'(1);
      end
    end
  end

`ifdef FL_DEBUG_EN
  logic recover_q;

  // Debug visibility of the raw state.
  always_comb begin
    array_o = fl_array;
    head_o  = head;
    tail_o  = tail;
  end

  // Remember the recovery so that the occupancy bound can be checked in the following cycle.
  always_ff @(posedge clk) begin
    if (rst) recover_q <= 1'b0;
    else     recover_q <= recover_en_i;
  end

  // Protocol checks: no push when full, sane occupancy after recovery, no X on the enables.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(retire_en_i && (free_cnt_o == (HT_W+1)'(FL_DEPTH))))
        else $error("free list: retire while full");
      assert (!recover_q || (free_cnt_o <= (HT_W+1)'(FL_DEPTH)))
        else $error("free list: occupancy exceeds depth after recovery");
      assert (!$isunknown({dispatch_en_i, retire_en_i, recover_en_i}))
        else $error("free list: X on enable");
    end
  end
`endif

endmodule

// File: tb/tb_preg_free_fifo.sv
// Directed bench for preg_free_fifo: reset, drain, refill, wrap, recovery and reset priority.
module tb_preg_free_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       dispatch_en_i;
  logic       retire_en_i;
  logic [5:0] retire_preg_i;
  logic       recover_en_i;
  logic [5:0] recover_head_i;
  logic       free_preg_vld_o;
  logic [5:0] free_preg_o;
  logic [5:0] free_preg_cur_head_o;
  logic [5:0] free_cnt_o;
`ifdef FL_DEBUG_EN
  logic [5:0] array_o [32];
  logic [5:0] head_o;
  logic [5:0] tail_o;
`endif

  int tests  = 0;
  int failed = 0;
  logic [5:0] ckpt;

  preg_free_fifo #(.PRF_W(6), .FL_DEPTH(32), .HT_W(5)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .dispatch_en_i        (dispatch_en_i),
    .retire_en_i          (retire_en_i),
    .retire_preg_i        (retire_preg_i),
    .recover_en_i         (recover_en_i),
    .recover_head_i       (recover_head_i),
`ifdef FL_DEBUG_EN
    .array_o              (array_o),
    .head_o               (head_o),
    .tail_o               (tail_o),
`endif
    .free_preg_vld_o      (free_preg_vld_o),
    .free_preg_o          (free_preg_o),
    .free_preg_cur_head_o (free_preg_cur_head_o),
    .free_cnt_o           (free_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        failed++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic idle();
    dispatch_en_i  = 1'b0;
    retire_en_i    = 1'b0;
    retire_preg_i  = '0;
    recover_en_i   = 1'b0;
    recover_head_i = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    // Reset state: the list is full with tags 32..63.
    check("rst_cnt",  free_cnt_o, 32);
    check("rst_vld",  free_preg_vld_o, 1);
    check("rst_preg", free_preg_o, 32);
    check("rst_head", free_preg_cur_head_o, 0);

    // Drain: 32 dispatches return tags 32..63 in order.
    for (int i = 0; i < 32; i++) begin
      check("drain_preg", free_preg_o, 32 + i);
      dispatch_en_i = 1'b1;
      tick();
    end
    dispatch_en_i = 1'b0;
    check("empty_vld",  free_preg_vld_o, 0);
    check("empty_cnt",  free_cnt_o, 0);
    check("empty_head", free_preg_cur_head_o, 32);

    // A dispatch while empty is ignored.
    dispatch_en_i = 1'b1;
    tick();
    check("empty_disp_head", free_preg_cur_head_o, 32);
    check("empty_disp_cnt",  free_cnt_o, 0);

    // A retire into the empty list with a same-cycle dispatch: no bypass, and the pop is dropped.
    retire_en_i   = 1'b1;
    retire_preg_i = 6'd5;
    tick();
    idle();
    check("refill_vld",  free_preg_vld_o, 1);
    check("refill_preg", free_preg_o, 5);
    check("refill_cnt",  free_cnt_o, 1);
    check("refill_head", free_preg_cur_head_o, 32);

    // Full list: dispatch and retire of tag 7 together.
    do_reset();
    dispatch_en_i = 1'b1;
    retire_en_i   = 1'b1;
    retire_preg_i = 6'd7;
    tick();
    idle();
    check("full_pair_cnt",  free_cnt_o, 32);
    check("full_pair_preg", free_preg_o, 33);
    // Tag 7 sits at index 0 and surfaces after 31 more pops.
    dispatch_en_i = 1'b1;
    repeat (31) tick();
    dispatch_en_i = 1'b0;
    check("full_pair_tail_tag", free_preg_o, 7);
    check("full_pair_tail_cnt", free_cnt_o, 1);

    // Wrap-around: 40 dispatch/retire pairs. The retired tags run 63,62,... and must come
    // back out in FIFO order.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      check("wrap_preg", free_preg_o, (i < 32) ? 32 + i : 63 - (i - 32));
      dispatch_en_i = 1'b1;
      retire_en_i   = 1'b1;
      retire_preg_i = 6'(63 - (i % 32));
      tick();
      check("wrap_cnt", free_cnt_o, 32);
    end
    idle();
    check("wrap_head", free_preg_cur_head_o, 40);

    // Recovery: checkpoint at head 3, pop 4 more, then recover with a same-cycle retire of 9.
    do_reset();
    dispatch_en_i = 1'b1;
    repeat (3) tick();
    dispatch_en_i = 1'b0;
    ckpt = free_preg_cur_head_o;
    check("ckpt_head", ckpt, 3);
    dispatch_en_i = 1'b1;
    repeat (4) tick();
    dispatch_en_i = 1'b0;
    check("pre_rec_preg", free_preg_o, 39);
    check("pre_rec_cnt",  free_cnt_o, 25);
    recover_en_i   = 1'b1;
    recover_head_i = ckpt;
    retire_en_i    = 1'b1;
    retire_preg_i  = 6'd9;
    tick();
    idle();
    check("rec_head", free_preg_cur_head_o, 3);
    check("rec_preg", free_preg_o, 35);
    check("rec_cnt",  free_cnt_o, 30);

    // Dispatch and recover together: the recovery target wins and the pop is dropped.
    dispatch_en_i = 1'b1;
    repeat (2) tick();
    check("pre_rec2_head", free_preg_cur_head_o, 5);
    recover_en_i   = 1'b1;
    recover_head_i = 6'd4;
    tick();
    idle();
    check("rec2_head", free_preg_cur_head_o, 4);
    check("rec2_preg", free_preg_o, 36);
    check("rec2_cnt",  free_cnt_o, 29);

    // Reset asserted together with recovery, retire and dispatch: reset wins.
    dispatch_en_i  = 1'b1;
    repeat (2) tick();
    rst            = 1'b1;
    recover_en_i   = 1'b1;
    recover_head_i = 6'd5;
    retire_en_i    = 1'b1;
    retire_preg_i  = 6'd2;
    tick();
    rst = 1'b0;
    idle();
    check("rst_mid_cnt",  free_cnt_o, 32);
    check("rst_mid_preg", free_preg_o, 32);
    check("rst_mid_head", free_preg_cur_head_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
